// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller for the in-order RV32 pipeline: N-stage operand
// forwarding, multi-cycle load-use stall, multi-cycle flush and saturating perf counters.
module hazard_fwd_ctrl #(
  parameter int REG_AW    = 5,
  parameter int NUM_FWD   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_AW-1:0]             ex_rs1,
  input  logic [REG_AW-1:0]             ex_rs2,
  input  logic [1:0]                    ex_rs_used,
  input  logic [NUM_FWD*REG_AW-1:0]     src_rd,
  input  logic [NUM_FWD-1:0]            src_we,
  input  logic [NUM_FWD-1:0]            src_ld,
  input  logic [6:0]                    op_ex,
  input  logic                          pcsrc,
  output logic [$clog2(NUM_FWD+1)-1:0]  fwd_a,
  output logic [$clog2(NUM_FWD+1)-1:0]  fwd_b,
  output logic                          stall,
  output logic                          flush,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int FC_W  = 3;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             haz;
    logic [SEL_W-1:0] len;
  } res_t;

  // Scans oldest to youngest so the youngest matching stage is the last to overwrite.
  function automatic res_t resolve(input logic [REG_AW-1:0]         rs,
                                   input logic                      used,
                                   input logic [NUM_FWD*REG_AW-1:0] rd_v,
                                   input logic [NUM_FWD-1:0]        we_v,
                                   input logic [NUM_FWD-1:0]        ld_v);
    res_t r;
    r = '0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (used && we_v[k-1] && (rd_v[k*REG_AW-1 -: REG_AW] != '0) &&
          (rd_v[k*REG_AW-1 -: REG_AW] == rs)) begin
        if (ld_v[k-1] && (k <= LOAD_LAT)) begin
          r.sel = '0;
          r.haz = 1'b1;
          r.len = SEL_W'(LOAD_LAT - k + 1);
        end else begin
          r.sel = SEL_W'(k);
          r.haz = 1'b0;
          r.len = '0;
        end
      end
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   scnt_q, scnt_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  res_t             res_a, res_b;
  logic             take, accept, haz, stall_raw, flush_raw;
  logic [SEL_W-1:0] len;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    res_a     = resolve(ex_rs1, ex_rs_used[0], src_rd, src_we, src_ld);
    res_b     = resolve(ex_rs2, ex_rs_used[1], src_rd, src_we, src_ld);
    haz       = res_a.haz | res_b.haz;
    len       = (res_a.len > res_b.len) ? res_a.len : res_b.len;
    take      = pcsrc && ((op_ex == OP_JAL) || (op_ex == OP_JALR) || (op_ex == OP_BR));
    accept    = 1'b0;
    state_d   = state_q;
    scnt_d    = scnt_q;
    fcnt_d    = fcnt_q;
    stall_raw = 1'b0;
    flush_raw = 1'b0;

    case (state_q)
      RUN, STALL: begin
        if (take) begin
          // A taken transfer squashes the EX instruction, so any pending stall is moot.
          flush_raw = 1'b1;
          accept    = 1'b1;
          scnt_d    = '0;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYC - 1);
          end else begin
            state_d = RUN;
          end
        end else if (state_q == STALL) begin
          stall_raw = 1'b1;
          if (scnt_q == SEL_W'(1)) begin
            state_d = RUN;
            scnt_d  = '0;
          end else begin
            scnt_d  = scnt_q - SEL_W'(1);
          end
        end else if (haz) begin
          stall_raw = 1'b1;
          if (len > SEL_W'(1)) begin
            state_d = STALL;
            scnt_d  = len - SEL_W'(1);
          end
        end
      end
      FLUSH: begin
        flush_raw = 1'b1;
        if (fcnt_q == FC_W'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = (stall_raw && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (accept && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      scnt_q      <= '0;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign fwd_a     = rst ? res_a.sel : '0;
  assign fwd_b     = rst ? res_b.sel : '0;
  assign stall     = rst & stall_raw;
  assign flush     = rst & flush_raw;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: two configurations share one stimulus stream and are
// checked every cycle against a remaining-cycles model plus directed literal checks.
module tb_hazard_fwd_ctrl;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_rs1, ex_rs2;
  logic [1:0]  ex_rs_used;
  logic [14:0] src_rd;
  logic [2:0]  src_we, src_ld;
  logic [6:0]  op_ex;
  logic        pcsrc;

  // Config 0: NUM_FWD=2 LOAD_LAT=1 FLUSH_CYC=2 CNT_W=16 (sees stages 1..2)
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic        a_stall, a_flush;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  // Config 1: NUM_FWD=3 LOAD_LAT=2 FLUSH_CYC=1 CNT_W=3
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic        b_stall, b_flush;
  logic [2:0]  b_stall_cnt, b_flush_cnt;

  hazard_fwd_ctrl #(.REG_AW(5), .NUM_FWD(2), .LOAD_LAT(1), .FLUSH_CYC(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs_used(ex_rs_used),
    .src_rd(src_rd[9:0]), .src_we(src_we[1:0]), .src_ld(src_ld[1:0]),
    .op_ex(op_ex), .pcsrc(pcsrc), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .stall(a_stall), .flush(a_flush), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_fwd_ctrl #(.REG_AW(5), .NUM_FWD(3), .LOAD_LAT(2), .FLUSH_CYC(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs_used(ex_rs_used),
    .src_rd(src_rd), .src_we(src_we), .src_ld(src_ld),
    .op_ex(op_ex), .pcsrc(pcsrc), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .stall(b_stall), .flush(b_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int nf_c[2]   = '{2, 3};
  int ll_c[2]   = '{1, 2};
  int fc_c[2]   = '{2, 1};
  int cmax_c[2] = '{65535, 7};
  int stall_left[2] = '{0, 0};
  int flush_left[2] = '{0, 0};
  int m_scnt[2]     = '{0, 0};
  int m_fcnt[2]     = '{0, 0};

  function automatic logic [4:0] rd_of(input int k);
    logic [14:0] v;
    v = src_rd;
    return v[k*5-1 -: 5];
  endfunction

  // Youngest matching stage decides: either it forwards, or it is a load still too young.
  function automatic void resolve(input int nf, input int ll, input logic [4:0] rs, input logic used,
                                  output int sel, output int len);
    sel = 0;
    len = 0;
    for (int k = 1; k <= nf; k++) begin
      if (used && src_we[k-1] && rd_of(k) != 5'd0 && rd_of(k) == rs) begin
        if (src_ld[k-1] && k <= ll) len = ll - k + 1;
        else sel = k;
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      int sa, la, sb, lb, len, e_stall, e_flush, acc;
      int g_fa, g_fb, g_st, g_fl, g_sc, g_fc;
      bit tk;
      if (c == 0) begin
        g_fa = a_fwd_a; g_fb = a_fwd_b; g_st = a_stall; g_fl = a_flush;
        g_sc = a_stall_cnt; g_fc = a_flush_cnt;
      end else begin
        g_fa = b_fwd_a; g_fb = b_fwd_b; g_st = b_stall; g_fl = b_flush;
        g_sc = b_stall_cnt; g_fc = b_flush_cnt;
      end
      sa = 0; sb = 0; len = 0; e_stall = 0; e_flush = 0; acc = 0;
      if (!rst) begin
        stall_left[c] = 0; flush_left[c] = 0; m_scnt[c] = 0; m_fcnt[c] = 0;
      end else begin
        resolve(nf_c[c], ll_c[c], ex_rs1, ex_rs_used[0], sa, la);
        resolve(nf_c[c], ll_c[c], ex_rs2, ex_rs_used[1], sb, lb);
        len = (la > lb) ? la : lb;
        tk  = pcsrc && (op_ex == OP_JAL || op_ex == OP_JALR || op_ex == OP_BR);
        if (flush_left[c] > 0) e_flush = 1;
        else if (tk) begin e_flush = 1; acc = 1; end
        else if (stall_left[c] > 0 || len > 0) e_stall = 1;
      end
      check($sformatf("cfg%0d fwd_a", c), g_fa, sa);
      check($sformatf("cfg%0d fwd_b", c), g_fb, sb);
      check($sformatf("cfg%0d stall", c), g_st, e_stall);
      check($sformatf("cfg%0d flush", c), g_fl, e_flush);
      check($sformatf("cfg%0d stall_cnt", c), g_sc, m_scnt[c]);
      check($sformatf("cfg%0d flush_cnt", c), g_fc, m_fcnt[c]);
      if (rst) begin
        if (flush_left[c] > 0) flush_left[c]--;
        else if (acc) begin flush_left[c] = fc_c[c] - 1; stall_left[c] = 0; end
        else if (stall_left[c] > 0) stall_left[c]--;
        else if (len > 0) stall_left[c] = len - 1;
        if (e_stall && m_scnt[c] < cmax_c[c]) m_scnt[c]++;
        if (acc && m_fcnt[c] < cmax_c[c]) m_fcnt[c]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_rs1 = '0; ex_rs2 = '0; ex_rs_used = '0;
    src_rd = '0; src_we = '0; src_ld = '0;
    op_ex = OP_ALU; pcsrc = 1'b0;
  endtask

  task automatic set_stage(input int k, input logic [4:0] rd, input logic we, input logic ld);
    src_rd[k*5-1 -: 5] = rd;
    src_we[k-1] = we;
    src_ld[k-1] = ld;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    // Reset state, with a hazard-looking pattern present
    set_stage(1, 5'd4, 1'b1, 1'b1); ex_rs1 = 5'd4; ex_rs_used = 2'b01;
    sample();
    check("reset stall", a_stall, 0);
    check("reset fwd_a", b_fwd_a, 0);
    check("reset stall_cnt", a_stall_cnt, 0);
    cycle();
    do_reset();

    // Forwarding priority
    set_stage(1, 5'd5, 1'b1, 1'b0); set_stage(2, 5'd5, 1'b1, 1'b0);
    ex_rs1 = 5'd5; ex_rs2 = 5'd5; ex_rs_used = 2'b01;
    sample();
    check("prio fwd_a", a_fwd_a, 1);
    check("prio fwd_b unused", a_fwd_b, 0);
    check("prio stall", a_stall, 0);
    cycle();
    set_stage(1, 5'd5, 1'b0, 1'b0); ex_rs_used = 2'b11;
    sample();
    check("prio we0 fwd_a", a_fwd_a, 2);
    check("prio we0 fwd_b", a_fwd_b, 2);
    cycle();

    // Single load-use on rs2 (cfg0 LOAD_LAT=1; cfg1 sees a 2-cycle stall)
    clear_inputs();
    do_reset();
    set_stage(1, 5'd7, 1'b1, 1'b1); ex_rs2 = 5'd7; ex_rs_used = 2'b10;
    sample();
    check("lu stall", a_stall, 1);
    check("lu fwd_b", a_fwd_b, 0);
    cycle();
    set_stage(1, 5'd0, 1'b0, 1'b0); set_stage(2, 5'd7, 1'b1, 1'b1);
    sample();
    check("lu fwd_b stage2", a_fwd_b, 2);
    check("lu stall released", a_stall, 0);
    check("lu stall_cnt", a_stall_cnt, 1);
    check("lu deep still stalled", b_stall, 1);
    cycle();
    set_stage(2, 5'd0, 1'b0, 1'b0); set_stage(3, 5'd7, 1'b1, 1'b1);
    sample();
    check("lu deep fwd_b", b_fwd_b, 3);
    check("lu deep stall_cnt", b_stall_cnt, 2);
    cycle();

    // Deep latency on rs1 (cfg1)
    do_reset();
    set_stage(1, 5'd3, 1'b1, 1'b1); ex_rs1 = 5'd3; ex_rs_used = 2'b01;
    sample();
    check("deep stall c1", b_stall, 1);
    cycle();
    set_stage(1, 5'd0, 1'b0, 1'b0); set_stage(2, 5'd3, 1'b1, 1'b1);
    sample();
    check("deep stall c2", b_stall, 1);
    check("deep fwd_a held", b_fwd_a, 0);
    cycle();
    set_stage(2, 5'd0, 1'b0, 1'b0); set_stage(3, 5'd3, 1'b1, 1'b1);
    sample();
    check("deep fwd_a", b_fwd_a, 3);
    check("deep stall off", b_stall, 0);
    check("deep stall_cnt", b_stall_cnt, 2);
    cycle();

    // Branch flush, one taken cycle, then not-taken branch
    do_reset();
    op_ex = OP_BR; pcsrc = 1'b1;
    sample();
    check("br flush c1", a_flush, 1);
    cycle();
    pcsrc = 1'b0;
    sample();
    check("br flush c2", a_flush, 1);
    check("br short flush", b_flush, 0);
    cycle();
    sample();
    check("br not taken", a_flush, 0);
    check("br flush_cnt", a_flush_cnt, 1);
    cycle();

    // Take while already flushing is ignored
    do_reset();
    op_ex = OP_BR; pcsrc = 1'b1;
    cycle();
    cycle();
    pcsrc = 1'b0;
    sample();
    check("flush ignore cnt0", a_flush_cnt, 1);
    check("flush ignore cnt1", b_flush_cnt, 2);
    cycle();

    // Flush beats stall
    do_reset();
    set_stage(1, 5'd7, 1'b1, 1'b1); ex_rs2 = 5'd7; ex_rs_used = 2'b10;
    op_ex = OP_JAL; pcsrc = 1'b1;
    sample();
    check("fbs flush", a_flush, 1);
    check("fbs stall", a_stall, 0);
    cycle();
    clear_inputs();
    cycle();
    cycle();
    sample();
    check("fbs no stall cycles", a_stall_cnt, 0);
    cycle();

    // Take arriving while cfg1 is in its multi-cycle stall
    do_reset();
    set_stage(1, 5'd3, 1'b1, 1'b1); ex_rs1 = 5'd3; ex_rs_used = 2'b01;
    cycle();
    set_stage(1, 5'd0, 1'b0, 1'b0); set_stage(2, 5'd3, 1'b1, 1'b1);
    op_ex = OP_JALR; pcsrc = 1'b1;
    sample();
    check("stall abort flush", b_flush, 1);
    check("stall abort stall", b_stall, 0);
    cycle();
    clear_inputs();
    sample();
    check("stall abort idle", b_stall, 0);
    check("stall abort stall_cnt", b_stall_cnt, 1);
    cycle();

    // x0 never forwards and never stalls
    set_stage(1, 5'd0, 1'b1, 1'b1); ex_rs1 = 5'd0; ex_rs_used = 2'b11;
    sample();
    check("x0 stall", a_stall, 0);
    check("x0 fwd_a", a_fwd_a, 0);
    cycle();

    // Reset asserted during a STALL cycle
    do_reset();
    set_stage(1, 5'd3, 1'b1, 1'b1); ex_rs1 = 5'd3; ex_rs_used = 2'b01;
    cycle();
    rst = 1'b0;
    #1;
    check("rst mid-stall stall", b_stall, 0);
    check("rst mid-stall stall_cnt", b_stall_cnt, 0);
    cycle();
    do_reset();

    // Counter saturation on the 3-bit configuration
    set_stage(2, 5'd9, 1'b1, 1'b1); ex_rs1 = 5'd9; ex_rs_used = 2'b01;
    for (int i = 0; i < 10; i++) cycle();
    clear_inputs();
    op_ex = OP_BR; pcsrc = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    clear_inputs();
    sample();
    check("sat stall_cnt", b_stall_cnt, 7);
    check("sat flush_cnt", b_flush_cnt, 7);
    check("alt flush_cnt", a_flush_cnt, 5);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised forwarding and hazard controller for the in-order RV32 pipeline. It is the successor to the single-source MW->DE forwarding unit.
- Generalisations: N forwarding source stages, configurable load-data latency, multi-cycle load-use stall counter, multi-cycle flush on taken control transfer, saturating stall/flush performance counters.
- Sits beside the decode/execute boundary. It drives operand-mux selects, the fetch/decode hold, and the pipeline-register flush.

Parameters:
- REG_AW, 5, register-address width.
- NUM_FWD, 2, number of forwarding source stages. Stage 1 is the youngest (directly after EX); stage NUM_FWD is the oldest.
- LOAD_LAT, 1, load data is usable for forwarding only from stage LOAD_LAT+1 onward (1..NUM_FWD-1).
- FLUSH_CYC, 1, cycles flush is held after a taken branch/jump (1..7).
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ex_rs1  in  REG_AW  source reg 1 of the instruction in EX.
- ex_rs2  in  REG_AW  source reg 2 of the instruction in EX.
- ex_rs_used  in  2  bit0 means rs1 is read, bit1 means rs2 is read.
- src_rd  in  NUM_FWD*REG_AW  dest reg per source stage; stage k occupies bits [k*REG_AW-1 -: REG_AW].
- src_we  in  NUM_FWD  regwrite per source stage.
- src_ld  in  NUM_FWD  stage k holds a load (opcode 0000011).
- op_ex  in  7  opcode in EX.
- pcsrc  in  1  control transfer taken, valid in EX.
- fwd_a  out  $clog2(NUM_FWD+1)  rs1 select: 0 means regfile, k means stage k.
- fwd_b  out  $clog2(NUM_FWD+1)  rs2 select, same encoding as fwd_a.
- stall  out  1  hold PC and IF/DE, insert a bubble into stage 1.
- flush  out  1  clear IF/DE and DE/EX.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.
- flush_cnt  out  CNT_W  taken-transfer events, saturating.

Behaviour:
- Reset (rst=0, asynchronous): FSM=RUN, counters 0, stall_cnt=0, flush_cnt=0. The combinational outputs therefore evaluate to stall=0, flush=0, fwd_a=fwd_b=0 while rst=0.
- Match rule for operand X (rs1/rs2): stage k matches if src_we[k], src_rd_k!=0, src_rd_k==ex_rsX and ex_rs_used bit set. The youngest matching stage (lowest k) wins.
- fwd_X: equals the winning k if not (src_ld[k] and k<=LOAD_LAT); otherwise 0. It is also 0 if no stage matches. It is combinational, with no latency.
- Load-use hazard: the winning stage k has src_ld[k] and k<=LOAD_LAT. Required stall length is L = LOAD_LAT-k+1. When both operands hazard, L is the maximum of the two.
- take: (op_ex==1101111 | 1100111 | 1100011) & pcsrc.
- FSM states: RUN, STALL, FLUSH.
- RUN:
  - If take: flush=1 and stall=0. If FLUSH_CYC>1, go to FLUSH with fcnt=FLUSH_CYC-1.
  - Else if hazard: stall=1. If L>1, go to STALL with scnt=L-1.
  - Else: stall=0, flush=0.
- STALL: stall=1. scnt decrements each cycle; return to RUN when scnt==1 at the clock edge. Forwarding selects keep evaluating combinationally.
- FLUSH: flush=1, stall=0. fcnt decrements; return to RUN when fcnt==1.
- Simultaneous events:
  - take in RUN or STALL has priority over hazard. It aborts any stall: scnt cleared, move to FLUSH (or RUN if FLUSH_CYC==1).
  - take while in FLUSH is ignored, because the EX instruction is already squashed.
- x0 is never forwarded and never stalls.
- Counters:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on each cycle where take is accepted (RUN or STALL).
  - Both saturate at all-ones, no wrap.
- Reset mid-stall or mid-flush returns immediately to RUN with outputs deasserted.

Test Plan:
- Forwarding priority: NUM_FWD=2; stage1 rd=5 ALU, stage2 rd=5 ALU, ex_rs1=5 -> fwd_a=1, stall=0. Stage1 we=0 -> fwd_a=2.
- Single load-use: LOAD_LAT=1; stage1 load rd=7, ex_rs2=7 -> stall=1 for exactly 1 cycle, then fwd_b=2 once the load reaches stage2, and stall_cnt=1.
- Deep latency: NUM_FWD=3, LOAD_LAT=2; stage1 load rd=3, ex_rs1=3 -> stall high 2 consecutive cycles, then fwd_a=3, stall_cnt=2.
- Branch flush: FLUSH_CYC=2, op_ex=1100011, pcsrc=1 for one cycle -> flush high 2 cycles, flush_cnt=1. Same stimulus with pcsrc=0 -> flush=0.
- Flush beats stall: load-use hazard and JAL (1101111) with pcsrc=1 in the same cycle -> flush=1, stall=0, no stall cycles follow.
- x0 and reset: stage1 load rd=0, ex_rs1=0 -> stall=0, fwd_a=0. Assert rst=0 during a STALL cycle -> stall drops immediately and counters read 0.
